drive_ramp_sequencer: RTL
=========================

// Module: drive_ramp_sequencer
// PURPOSE
//  Parametrised successor to the two-channel drive direction decoder. Decodes DIR_STATE/PWM_STATE
//  into per-channel direction and power for MC1 (right) and MC2 (left). Also adds:
//  - soft-start/soft-stop power ramping
//  - enforced neutral dead time before any direction reversal
//  - a settled status flag
//  Sits between the navigation command logic and the motor-controller output pins.
// PARAMETERS
//  PWR_W       3   power-level width; MC outputs are PWR_W+2 bits wide
//  RAMP_DIV    4   CLK cycles per ramp step (>=1; 1 = step every cycle)
//  DEADTIME    8   CLK cycles held in neutral at level 0 before a reversal
//  DEFAULT_PWR 1   target level when PWM_STATE[1:0] != 2'b11
//  WDOG_CYCLES 100 watchdog timeout in CLK cycles (used only with DRIVE_WATCHDOG_EN)
// PORTS
//  CLK        in   1        system clock, rising edge
//  RST        in   1        asynchronous reset, active-high
//  DIR_STATE  in   5        drive command, same encodings as the existing direction decoder
//  PWM_STATE  in   PWR_W+2  [1:0]==2'b11: target level = [PWR_W+1:2]; otherwise DEFAULT_PWR
//  CMD_STB    in   1        one-cycle pulse per new command (watchdog kick)
//  MC1        out  PWR_W+2  right MC: [1:0] dir (00 fwd, 01 neutral, 10 rev), [PWR_W+1:2] level
//  MC2        out  PWR_W+2  left MC, same packing as MC1
//  SETTLED    out  1        both channels at target direction and target level
//  WDOG_TRIP  out  1        watchdog timeout active
// BEHAVIOUR
//  - Reset (async): MC1 = MC2 = {0, 2'b01}; SETTLED = 1; WDOG_TRIP = 0; channel FSMs in STOP;
//    prescaler, dead counters and watchdog counter cleared.
//  - Target decode, per channel {MC1,MC2}:
//      NEUTRAL 00000 = N,N;  FORWARD 00001 = F,F;  REVERSE 00010 = R,R;
//      FORWARD_RIGHT 00011 = N,F;  BACK_RIGHT 00111 = R,N;
//      FORWARD_LEFT 11000 = F,N;  BACK_LEFT 10000 = N,R;
//      R_360 10011 = R,F;  L_360 11001 = F,R.
//    Any other code targets N,N.
//  - Target level is common to both channels. A channel targeting N has effective target 0.
//  - Prescaler: counts 0..RAMP_DIV-1 and wraps; TICK asserts in the cycle it equals RAMP_DIV-1.
//    The prescaler is shared and free-running.
//  - Each channel runs an independent FSM {STOP, RAMP, DECEL, DEAD}:
//      STOP : dir out 01, lvl 0. Target dir F/R -> RAMP next clock with cur_dir = target, lvl 0.
//      RAMP : dir out = cur_dir. On TICK, lvl moves 1 toward target (up or down); no overshoot.
//             Target dir != cur_dir (N or opposite) -> DECEL.
//      DECEL: dir out = cur_dir. On TICK, lvl decrements by 1. Exits:
//             - lvl == 0 -> DEAD (dir out 01).
//             - target returns to cur_dir before lvl reaches 0 -> RAMP; no dead time,
//               ramp continues from the current lvl.
//      DEAD : dir out 01, lvl 0. Counts DEADTIME clocks (not ticks), then -> STOP.
//             Target changes during DEAD do not shorten it.
//  - Direction never changes F<->R without passing through DECEL and DEAD.
//  - Outputs are registered: MC reflects the FSM state/level updated on the same edge,
//    so a command change becomes visible one clock later at the earliest.
//  - Level arithmetic is unsigned PWR_W bits, saturating at 0 and at 2^PWR_W-1; it never wraps.
//  - A target change mid-ramp redirects the ramp from the current lvl on the next TICK.
//  - SETTLED = every channel has (dir out == target dir AND lvl == effective target) and no
//    channel is in DEAD. Registered.
//  - Simultaneous TICK and DECEL-exit: the decrement to 0 and the entry to DEAD occur on the
//    same edge.
// CONFIGURATION
//  DRIVE_WATCHDOG_EN defined:
//    - Counter clears on CMD_STB; when it reaches WDOG_CYCLES, WDOG_TRIP = 1.
//    - While WDOG_TRIP = 1, both targets are forced to N (normal ramp-down and DEAD apply).
//    - The next CMD_STB clears WDOG_TRIP and the counter on the same edge.
//  DRIVE_WATCHDOG_EN undefined:
//    - No counter; WDOG_TRIP tied 0; CMD_STB ignored.
// TESTING  (PWR_W=3, RAMP_DIV=4, DEADTIME=8, DEFAULT_PWR=1, WDOG_CYCLES=100)
//  1. FORWARD, PWM_STATE=5'b11111
//     -> MC1/MC2[1:0]=00; level +1 every 4 clks; 7 reached in <=29 clks; then SETTLED=1.
//  2. From fwd lvl 7, REVERSE
//     -> dir 00 while level falls 7->0 (~28 clks); then 5'b00001 for 8 clks; then dir 10 ramps to 7.
//     -> MC never shows 00 and 10 with lvl>0 in consecutive states.
//  3. FORWARD_RIGHT, PWM_STATE[1:0]=2'b00
//     -> MC1 = 5'b00001 constant; MC2 dir 00, level ramps to 1; SETTLED=1.
//  4. Fwd lvl 7, REVERSE for 8 clks (lvl 5), then FORWARD
//     -> no neutral on MC1/MC2; level ramps 5->7.
//  5. RST pulse mid-ramp (lvl 4)
//     -> MC1 = MC2 = 5'b00001 in the same cycle (async); after release, ramp restarts from 0.
//  6. DRIVE_WATCHDOG_EN, FORWARD lvl 7, no CMD_STB
//     -> WDOG_TRIP=1 at 100 clks; both channels ramp to 0 then neutral.
//     -> CMD_STB clears WDOG_TRIP; FORWARD resumes ramping.

Source files
------------

// File: rtl/drive_ramp_sequencer.sv
// Purpose : two-channel drive decoder with soft-start/stop ramping, neutral dead time before reversal, settled flag.
// Latency : 1 clock from DIR_STATE/PWM_STATE to MC1/MC2/SETTLED (all outputs registered).
// Backpress: none; commands are level-sampled every clock, CMD_STB only kicks the optional watchdog.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous reset, active-high
//   DIR_STATE  5-bit drive command (same encodings as the legacy direction decoder)
//   PWM_STATE  [1:0]==2'b11 selects target level [PWR_W+1:2], otherwise DEFAULT_PWR
//   CMD_STB    one-cycle pulse per new command (watchdog kick)
//   MC1 / MC2  right / left motor controller: [1:0] dir (00 fwd, 01 neutral, 10 rev), [PWR_W+1:2] level
//   SETTLED    both channels at target direction and target level, neither in dead time
//   WDOG_TRIP  command watchdog expired
//
// Optional feature: define DRIVE_WATCHDOG_EN to build the command watchdog.

module drive_ramp_sequencer #(
    parameter int PWR_W       = 3,
    parameter int RAMP_DIV    = 4,
    parameter int DEADTIME    = 8,
    parameter int DEFAULT_PWR = 1,
    parameter int WDOG_CYCLES = 100
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       DIR_STATE,
    input  logic [PWR_W+1:0] PWM_STATE,
    input  logic             CMD_STB,
    output logic [PWR_W+1:0] MC1,
    output logic [PWR_W+1:0] MC2,
    output logic             SETTLED,
    output logic             WDOG_TRIP
);

    localparam logic [1:0] DIR_FWD = 2'b00;
    localparam logic [1:0] DIR_NEU = 2'b01;
    localparam logic [1:0] DIR_REV = 2'b10;

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DT_W  = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RAMP,
        ST_DECEL,
        ST_DEAD
    } ch_state_e;

    // ------------------------------------------------------------------
    // Shared free-running ramp prescaler
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick;

    always_comb begin
        tick    = (presc_q == PRE_W'(RAMP_DIV - 1));
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Command watchdog
    // ------------------------------------------------------------------
    logic wdog_trip_q;

`ifdef DRIVE_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic            wdog_trip_d;

    // Counter parks at WDOG_CYCLES so the trip stays asserted until the next kick.
    always_comb begin
        wdog_cnt_d  = wdog_cnt_q;
        wdog_trip_d = wdog_trip_q;
        if (CMD_STB) begin
            wdog_cnt_d  = '0;
            wdog_trip_d = 1'b0;
        end else begin
            if (wdog_cnt_q != WD_W'(WDOG_CYCLES)) begin
                wdog_cnt_d = wdog_cnt_q + WD_W'(1);
            end
            wdog_trip_d = (wdog_cnt_d == WD_W'(WDOG_CYCLES));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdog_cnt_q  <= '0;
            wdog_trip_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end
`else
    logic wdog_unused;

    assign wdog_trip_q = 1'b0;
    assign wdog_unused = CMD_STB;
`endif

    // ------------------------------------------------------------------
    // Target decode: index 0 = MC1 (right), index 1 = MC2 (left)
    // ------------------------------------------------------------------
    logic [1:0][1:0]  tgt_dir;
    logic [PWR_W-1:0] tgt_lvl;

    always_comb begin
        tgt_dir = {DIR_NEU, DIR_NEU};
        case (DIR_STATE)
            5'b00001: tgt_dir = {DIR_FWD, DIR_FWD};  // FORWARD
            5'b00010: tgt_dir = {DIR_REV, DIR_REV};  // REVERSE
            5'b00011: tgt_dir = {DIR_FWD, DIR_NEU};  // FORWARD_RIGHT
            5'b00111: tgt_dir = {DIR_NEU, DIR_REV};  // BACK_RIGHT
            5'b11000: tgt_dir = {DIR_NEU, DIR_FWD};  // FORWARD_LEFT
            5'b10000: tgt_dir = {DIR_REV, DIR_NEU};  // BACK_LEFT
            5'b10011: tgt_dir = {DIR_FWD, DIR_REV};  // R_360
            5'b11001: tgt_dir = {DIR_REV, DIR_FWD};  // L_360
            default:  tgt_dir = {DIR_NEU, DIR_NEU};  // NEUTRAL and unknown codes
        endcase
        // An expired watchdog parks both wheels through the normal ramp-down path.
        if (wdog_trip_q) begin
            tgt_dir = {DIR_NEU, DIR_NEU};
        end
        tgt_lvl = (PWM_STATE[1:0] == 2'b11) ? PWM_STATE[PWR_W+1:2] : PWR_W'(DEFAULT_PWR);
    end

    // ------------------------------------------------------------------
    // Per-channel ramp FSMs
    // ------------------------------------------------------------------
    logic [1:0][PWR_W+1:0] ch_mc;
    logic [1:0]            ch_ok;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        ch_state_e        state_q, state_d;
        logic [1:0]       dir_q, dir_d, tdir, dout_d;
        logic [PWR_W-1:0] lvl_q, lvl_d, elvl, lvl_inc, lvl_dec, lvl_brk;
        logic [DT_W-1:0]  dcnt_q, dcnt_d;
        logic [PWR_W+1:0] mc_q;

        assign tdir = tgt_dir[g];
        assign elvl = (tdir == DIR_NEU) ? '0 : tgt_lvl;

        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            lvl_d   = lvl_q;
            dcnt_d  = dcnt_q;
            lvl_inc = (lvl_q == '1) ? lvl_q : lvl_q + PWR_W'(1);
            lvl_dec = (lvl_q == '0) ? lvl_q : lvl_q - PWR_W'(1);
            lvl_brk = tick ? lvl_dec : lvl_q;

            case (state_q)
                ST_STOP: begin
                    lvl_d  = '0;
                    dcnt_d = '0;
                    if (tdir != DIR_NEU) begin
                        state_d = ST_RAMP;
                        dir_d   = tdir;
                    end
                end
                ST_RAMP: begin
                    if (tdir == dir_q) begin
                        // Move one step toward the (possibly changed) target; never past it.
                        if (tick && (lvl_q < elvl)) begin
                            lvl_d = lvl_inc;
                        end else if (tick && (lvl_q > elvl)) begin
                            lvl_d = lvl_dec;
                        end
                    end else begin
                        state_d = ST_DECEL;
                    end
                end
                ST_DECEL: begin
                    if (tdir == dir_q) begin
                        // Command came back before standstill: resume from current level.
                        state_d = ST_RAMP;
                    end else begin
                        lvl_d = lvl_brk;
                        // The decrement that reaches zero also enters dead time.
                        if (lvl_brk == '0) begin
                            state_d = ST_DEAD;
                            dcnt_d  = '0;
                        end
                    end
                end
                ST_DEAD: begin
                    lvl_d = '0;
                    if (dcnt_q == DT_W'(DEADTIME - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        dcnt_d = dcnt_q + DT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_STOP;
                    lvl_d   = '0;
                end
            endcase

            dout_d = ((state_d == ST_RAMP) || (state_d == ST_DECEL)) ? dir_d : DIR_NEU;
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q <= ST_STOP;
                dir_q   <= DIR_NEU;
                lvl_q   <= '0;
                dcnt_q  <= '0;
                mc_q    <= {{PWR_W{1'b0}}, DIR_NEU};
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
                lvl_q   <= lvl_d;
                dcnt_q  <= dcnt_d;
                mc_q    <= {lvl_d, dout_d};
            end
        end

        assign ch_mc[g] = mc_q;
        assign ch_ok[g] = (dout_d == tdir) && (lvl_d == elvl) && (state_d != ST_DEAD);
    end

    // ------------------------------------------------------------------
    // Registered status
    // ------------------------------------------------------------------
    logic settled_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            settled_q <= 1'b1;
        end else begin
            settled_q <= &ch_ok;
        end
    end

    assign MC1       = ch_mc[0];
    assign MC2       = ch_mc[1];
    assign SETTLED   = settled_q;
    assign WDOG_TRIP = wdog_trip_q;

endmodule
